// File: rtl/div_unit.sv
// Iterative restoring unsigned divider for the DIV opcode: one quotient bit per
// clock, start/busy/done handshake, results held in dedicated output registers.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             zeroFlag,
  output logic             signFlag,
  output logic             carryFlag
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_div, r_rem, r_quo;
  logic [WIDTH-1:0] r_q_out, r_r_out;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;

  // Shifted partial remainder needs one extra bit: with a divisor above
  // 2^(WIDTH-1) the shifted value can exceed WIDTH bits before subtraction.
  logic [WIDTH:0]   w_rem_sh, w_trial;
  logic             w_fit, w_last;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;

  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_div};
  assign w_fit     = ~w_trial[WIDTH];
  assign w_rem_nxt = w_fit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (start) begin
            if (b == '0) begin
              r_q_out <= '1;
              r_r_out <= a;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_div   <= b;
              r_rem   <= '0;
              r_quo   <= a;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Working registers are separate from the outputs, so a flush
          // leaves the last completed result visible.
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_q_out <= w_quo_nxt;
              r_r_out <= w_rem_nxt;
              r_dbz   <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_q_out;
  assign remainder = r_r_out;
  assign divByZero = r_dbz;
  assign zeroFlag  = (r_q_out == '0);
  assign signFlag  = r_q_out[WIDTH-1];
  assign carryFlag = 1'b0;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit unsigned divider that implements the DIV opcode (12), which the combinational ALU does not compute. It sits beside the ALU in the execute stage and feeds the execute result mux with quotient, remainder and flags. The execute stage selects this unit's output in place of the ALU result when opSel = DIV. Division uses a start/busy/done handshake, so the pipeline must stall while busy is high.

## Interface
Parameters:
- WIDTH, 32, operand and result width; all widths below assume WIDTH = 32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- start  in  1  request a division; sampled only in IDLE or DONE.
- flush  in  1  synchronous abort; returns the unit to IDLE.
- a  in  32  dividend; sampled on the accepting start edge.
- b  in  32  divisor; sampled on the accepting start edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  32  a / b, unsigned.
- remainder  out  32  a % b, unsigned.
- divByZero  out  1  high when the last completed operation had b = 0.
- zeroFlag  out  1  high when quotient == 0.
- signFlag  out  1  equals quotient[31].
- carryFlag  out  1  always 0.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE or DONE with start=1, b!=0:
  - Latch divisor = b.
  - Clear the remainder register; quotient register = a.
  - Clear iteration counter (6 bits).
  - Go to RUN.
- IDLE or DONE with start=1, b=0:
  - Go directly to DONE with quotient = 0xFFFFFFFF, remainder = a, divByZero = 1.
- RUN, one restoring step per edge:
  - Shift {rem, quo} left 1.
  - trial = rem_shifted − divisor, computed 33 bits wide.
  - If trial is non-negative: rem = trial[31:0] and quo[0] = 1; otherwise keep rem_shifted and quo[0] = 0.
  - Increment the counter.
- RUN → DONE on the edge that completes step 32 (counter == 31 before that edge).
- DONE → IDLE on the next edge when start=0.
- Outputs quotient, remainder, divByZero and the flags hold their values until the next accepted start. They are driven from the result registers and do not glitch during RUN.
- start while in RUN is ignored and is not queued.
- flush while in RUN:
  - Go to IDLE.
  - Outputs revert to the values from the last completed operation.
  - No done pulse.
- flush has priority over start on the same edge.
- Reset (rstN low, at any time, including mid-RUN): state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, divByZero = 0. zeroFlag is 1 because quotient == 0. signFlag = 0, carryFlag = 0.

## Timing
- Accepting start edge = edge 0.
  - b != 0: busy is high in cycles 1..32, and done is high in cycle 33 only (the cycle after edge 32).
  - b = 0: done is high in cycle 1; busy never rises.
- Back-to-back operation: start held high during the done cycle is accepted on that edge, so the next busy starts with no idle gap.
- Latency is data-independent: always 32 cycles of RUN plus one done cycle.
- Release of rstN is synchronous to clk at the bench. The unit makes no recovery guarantees beyond the standard flop behaviour.

## Test plan
- a=100, b=7, start pulsed one cycle:
  - busy is high for exactly 32 cycles, then done pulses once.
  - quotient = 14, remainder = 2, zeroFlag = 0, divByZero = 0.
- a=0xFFFFFFFF, b=1:
  - quotient = 0xFFFFFFFF, remainder = 0, signFlag = 1.
- a=3, b=10:
  - quotient = 0, remainder = 3, zeroFlag = 1.
- a=5, b=0:
  - done pulses in cycle 1 and busy never asserts.
  - quotient = 0xFFFFFFFF, remainder = 5, divByZero = 1.
- a=100, b=7 started, then start with a=9, b=3 at cycle 10:
  - The second start is ignored; the result is 14/2 at cycle 33.
  - A new start held through the done cycle is accepted immediately; its result is 3/0.
- a=100, b=7 started:
  - flush at cycle 15: unit returns to IDLE, no done pulse, outputs hold the previous results.
  - Separately, rstN low at cycle 15: all outputs go to their reset values asynchronously. A subsequent 100/7 completes normally.
